// File: rtl/lsu_ram_port_if.sv
// Core-side request/response handshake and RAM-side port of the LSU front-end.
// Signal names carry the direction as seen from the LSU (i_ = into it, o_ = out of it).
interface lsu_ram_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_req_valid;
    logic                  o_req_ready;
    logic                  i_req_we;
    logic [1:0]            i_req_size;
    logic                  i_req_unsigned;
    logic [ADDR_WIDTH-1:0] i_req_addr;
    logic [DATA_WIDTH-1:0] i_req_wdata;
    logic                  o_rsp_valid;
    logic                  i_rsp_ready;
    logic [DATA_WIDTH-1:0] o_rsp_rdata;
    logic                  o_rsp_err;
    logic [ADDR_WIDTH-1:0] o_ram_read_addr;
    logic [DATA_WIDTH-1:0] i_ram_read_data;
    logic                  o_ram_write_en;
    logic [3:0]            o_ram_byte_en;
    logic [ADDR_WIDTH-1:0] o_ram_write_addr;
    logic [DATA_WIDTH-1:0] o_ram_write_data;

    modport slave (
        input  i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
        input  i_rsp_ready, i_ram_read_data,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        output o_ram_read_addr, o_ram_write_en, o_ram_byte_en, o_ram_write_addr, o_ram_write_data
    );

    modport master (
        output i_req_valid, i_req_we, i_req_size, i_req_unsigned, i_req_addr, i_req_wdata,
        output i_rsp_ready, i_ram_read_data,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
        input  o_ram_read_addr, o_ram_write_en, o_ram_byte_en, o_ram_write_addr, o_ram_write_data
    );
endinterface

// File: rtl/lsu_ram_port.sv
// Load/store front-end for a byte-lane local RAM with 1-cycle registered reads.
// One request in flight; stores commit before their response, loads return extended data.
module lsu_ram_port #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WORD_COUNT = 1024
) (
    input logic           i_clk,
    input logic           i_rst_n,
    input logic           i_clk_en,
    lsu_ram_port_if.slave bus
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] WORD_LIMIT = IDX_W'(WORD_COUNT);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, RESP} state_e;

    state_e                state_q, state_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [1:0]            lane_q, lane_d;
    logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
    logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
    logic                  write_en_q, write_en_d;
    logic [3:0]            byte_en_q, byte_en_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic                  req_err;
    logic [3:0]            store_be;
    logic [DATA_WIDTH-1:0] store_data;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] load_data;

    assign word_addr = {2'b00, bus.i_req_addr[ADDR_WIDTH-1:2]};

    // Request decode: legality plus the lane-replicated store image.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        req_err    = 1'b0;
        store_be   = 4'b1111;
        store_data = bus.i_req_wdata;
        case (bus.i_req_size)
            2'b00: begin
                store_be   = 4'b0001 << bus.i_req_addr[1:0];
                store_data = {4{bus.i_req_wdata[7:0]}};
            end
            2'b01: begin
                req_err    = bus.i_req_addr[0];
                store_be   = bus.i_req_addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{bus.i_req_wdata[15:0]}};
            end
            2'b10:   req_err = |bus.i_req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if (bus.i_req_addr[ADDR_WIDTH-1:2] >= WORD_LIMIT) req_err = 1'b1;
    end

    always_comb begin
        ld_byte   = bus.i_ram_read_data[{lane_q, 3'b000} +: 8];
        ld_half   = lane_q[1] ? bus.i_ram_read_data[31:16] : bus.i_ram_read_data[15:0];
        load_data = bus.i_ram_read_data;
        case (size_q)
            2'b00:   load_data = {{24{~unsigned_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{~unsigned_q & ld_half[15]}}, ld_half};
            default: load_data = bus.i_ram_read_data;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        lane_d       = lane_q;
        read_addr_d  = read_addr_q;
        write_addr_d = write_addr_q;
        write_en_d   = write_en_q;
        byte_en_d    = byte_en_q;
        write_data_d = write_data_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_rdata_d  = rsp_rdata_q;
        case (state_q)
            IDLE: if (bus.i_req_valid) begin
                size_d     = bus.i_req_size;
                unsigned_d = bus.i_req_unsigned;
                lane_d     = bus.i_req_addr[1:0];
                if (req_err) begin
                    state_d = RESP;
                end else if (!bus.i_req_we) begin
                    read_addr_d = word_addr;
                    state_d     = RD_ADDR;
                end else begin
                    write_addr_d = word_addr;
                    write_en_d   = 1'b1;
                    byte_en_d    = store_be;
                    write_data_d = store_data;
                    state_d      = WR;
                end
            end
            WR: begin
                write_en_d  = 1'b0;
                byte_en_d   = 4'b0000;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                state_d     = RESP;
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                rsp_rdata_d = load_data;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                // Only an error reaches RESP with no response raised yet; raise it one cycle after accept.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else if (bus.i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            lane_q       <= 2'b00;
            read_addr_q  <= '0;
            write_addr_q <= '0;
            write_en_q   <= 1'b0;
            byte_en_q    <= 4'b0000;
            write_data_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else if (i_clk_en) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            lane_q       <= lane_d;
            read_addr_q  <= read_addr_d;
            write_addr_q <= write_addr_d;
            write_en_q   <= write_en_d;
            byte_en_q    <= byte_en_d;
            write_data_q <= write_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    assign bus.o_req_ready      = (state_q == IDLE);
    assign bus.o_rsp_valid      = rsp_valid_q;
    assign bus.o_rsp_err        = rsp_err_q;
    assign bus.o_rsp_rdata      = rsp_rdata_q;
    assign bus.o_ram_read_addr  = read_addr_q;
    assign bus.o_ram_write_addr = write_addr_q;
    assign bus.o_ram_write_en   = write_en_q;
    assign bus.o_ram_byte_en    = byte_en_q;
    assign bus.o_ram_write_data = write_data_q;
endmodule
